// File: rtl/async_fifo_read_ctrl.sv
//============================================================================
// Module  : async_fifo_read_ctrl
// Purpose : Read-domain control half of an asynchronous FIFO. It brings the
//           write-side Gray pointer into read_clk through a flop chain. It
//           also owns the binary and Gray read pointers and drives the RAM
//           read address. From next-state values it produces registered
//           empty, almost-empty, fill-level and underflow outputs. The Gray
//           read pointer is exported straight from a flop, so the write
//           domain can synchronize it without glitches.
//
// Parameters
//   SIZE_LOG2         log2 of FIFO depth; pointers carry one extra wrap bit
//   SYNC_STAGES       flops in the write-pointer synchronizer (2..4)
//   ALMOST_EMPTY_THR  read_almost_empty is set when level <= this value
//
// Ports
//   read_clk           in   1            read-domain clock
//   read_rst           in   1            asynchronous reset, active-high
//   w_write_ptr_gray   in   SIZE_LOG2+1  write Gray pointer (write_clk domain)
//   p_read_en          in   1            read request
//   p_read_empty       out  1            FIFO empty (registered)
//   read_almost_empty  out  1            level <= ALMOST_EMPTY_THR (registered)
//   read_level         out  SIZE_LOG2+1  occupancy seen by the read side
//   read_underflow     out  1            one-cycle pulse: read while empty
//   read_addr          out  SIZE_LOG2    RAM read address
//   r_read_ptr_bin     out  SIZE_LOG2+1  binary read pointer
//   r_read_ptr_gray    out  SIZE_LOG2+1  Gray read pointer (flop output)
//============================================================================
module async_fifo_read_ctrl #(
    parameter int SIZE_LOG2        = 5,
    parameter int SYNC_STAGES      = 2,
    parameter int ALMOST_EMPTY_THR = 2
) (
    input  logic                 read_clk,
    input  logic                 read_rst,
    input  logic [SIZE_LOG2:0]   w_write_ptr_gray,
    input  logic                 p_read_en,
    output logic                 p_read_empty,
    output logic                 read_almost_empty,
    output logic [SIZE_LOG2:0]   read_level,
    output logic                 read_underflow,
    output logic [SIZE_LOG2-1:0] read_addr,
    output logic [SIZE_LOG2:0]   r_read_ptr_bin,
    output logic [SIZE_LOG2:0]   r_read_ptr_gray
);

    localparam int              PW     = SIZE_LOG2 + 1;
    localparam logic [PW-1:0]   AE_THR = PW'(ALMOST_EMPTY_THR);
    localparam logic [PW-1:0]   DEPTH  = PW'(2 ** SIZE_LOG2);

    // Converts a Gray pointer back to binary. Each binary bit is the XOR of
    // all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_wptrSync [SYNC_STAGES];

    logic          w_accept;
    logic [PW-1:0] w_wptrSync;
    logic [PW-1:0] w_wptrSyncBin;
    logic [PW-1:0] w_binNext;
    logic [PW-1:0] w_grayNext;
    logic [PW-1:0] w_levelNext;

    // The synchronizer has no logic in front of its first flop. Only one
    // bit of the Gray input changes at a time, so a metastable first stage
    // can only resolve to the old pointer or the new one.
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_wptrSync[i] <= '0;
            end
        end else begin
            r_wptrSync[0] <= w_write_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wptrSync[i] <= r_wptrSync[i-1];
            end
        end
    end

    assign w_wptrSync = r_wptrSync[SYNC_STAGES-1];

    // A read is accepted only against the registered empty flag. As a
    // result, a request that arrives while the FIFO is empty never moves
    // the pointers.
    always_comb begin
        w_accept      = p_read_en & ~p_read_empty;
        w_binNext     = r_read_ptr_bin + {{(PW-1){1'b0}}, w_accept};
        w_grayNext    = w_binNext ^ (w_binNext >> 1);
        w_wptrSyncBin = gray2bin(w_wptrSync);
        w_levelNext   = w_wptrSyncBin - w_binNext;
    end

    // The pointers and all flags come from next-state values. A read that
    // drains the FIFO therefore raises empty on the same edge that moves
    // the pointer. The stale synchronized write pointer can only under-state
    // the level, so empty may be late to fall but is never early.
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            r_read_ptr_bin    <= '0;
            r_read_ptr_gray   <= '0;
            p_read_empty      <= 1'b1;
            read_almost_empty <= 1'b1;
            read_level        <= '0;
            read_underflow    <= 1'b0;
        end else begin
            r_read_ptr_bin    <= w_binNext;
            r_read_ptr_gray   <= w_grayNext;
            p_read_empty      <= (w_grayNext == w_wptrSync);
            read_almost_empty <= (w_levelNext <= AE_THR);
            read_level        <= w_levelNext;
            read_underflow    <= p_read_en & p_read_empty;
        end
    end

    assign read_addr = r_read_ptr_bin[SIZE_LOG2-1:0];

    // Structural invariants of the read side. Simulation checks these
    // properties; synthesis ignores them.
    aGrayMatchesBin : assert property (@(posedge read_clk) disable iff (read_rst)
        r_read_ptr_gray == (r_read_ptr_bin ^ (r_read_ptr_bin >> 1)));

    aGraySingleStep : assert property (@(posedge read_clk) disable iff (read_rst)
        $onehot0(r_read_ptr_gray ^ $past(r_read_ptr_gray)));

    aNoReadWhenEmpty : assert property (@(posedge read_clk) disable iff (read_rst)
        p_read_empty |=> $stable(r_read_ptr_bin));

    aLevelBounded : assert property (@(posedge read_clk) disable iff (read_rst)
        read_level <= DEPTH);

endmodule

// File: tb/tb_async_fifo_read_ctrl.sv
//============================================================================
// Testbench for async_fifo_read_ctrl. The stimulus process drives reads and
// write-pointer steps, and models the FIFO as plain write and read counts
// with a delay line for the synchronizer. For every clock edge it queues the
// outputs it expects. A separate monitor process pops those expectations
// after each edge and compares them against the DUT.
//============================================================================
module tb_async_fifo_read_ctrl;

    localparam int SL    = 5;
    localparam int SS    = 2;
    localparam int AET   = 2;
    localparam int DEPTH = 32;
    localparam int MODV  = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [SL:0]  wGray = '0;
    logic         rdEn  = 1'b0;
    logic         empty;
    logic         almostEmpty;
    logic [SL:0]  level;
    logic         underflow;
    logic [SL-1:0] addr;
    logic [SL:0]  ptrBin;
    logic [SL:0]  ptrGray;

    async_fifo_read_ctrl #(
        .SIZE_LOG2        (SL),
        .SYNC_STAGES      (SS),
        .ALMOST_EMPTY_THR (AET)
    ) dut (
        .read_clk          (clock),
        .read_rst          (reset),
        .w_write_ptr_gray  (wGray),
        .p_read_en         (rdEn),
        .p_read_empty      (empty),
        .read_almost_empty (almostEmpty),
        .read_level        (level),
        .read_underflow    (underflow),
        .read_addr         (addr),
        .r_read_ptr_bin    (ptrBin),
        .r_read_ptr_gray   (ptrGray)
    );

    always #5 clock = ~clock;

    typedef struct {
        int bin;
        int lvl;
        bit emp;
        bit ae;
        bit uf;
    } expT;

    expT expQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: counts of words written and read, plus a delay line
    // that holds the write count as the read side currently sees it.
    int wrCount = 0;
    int rdCount = 0;
    int syncPipe[SS];
    bit mEmpty  = 1'b1;

    function automatic int grayOf(input int b);
        return b ^ (b >> 1);
    endfunction

    // Single comparison point; both checking paths count through here.
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compares one queued expectation with what the DUT shows after an edge.
    task automatic checkOutput(input expT e);
        compare("ptr_bin",      32'(ptrBin),      32'(e.bin));
        compare("ptr_gray",     32'(ptrGray),     32'(grayOf(e.bin)));
        compare("read_addr",    32'(addr),        32'(e.bin % DEPTH));
        compare("read_level",   32'(level),       32'(e.lvl));
        compare("empty",        32'(empty),       32'(e.emp));
        compare("almost_empty", 32'(almostEmpty), 32'(e.ae));
        compare("underflow",    32'(underflow),   32'(e.uf));
    endtask

    // Drives one cycle of stimulus, then advances the model across the
    // coming edge and queues the outputs that edge should produce. The
    // writer never lets more than DEPTH words be outstanding.
    task automatic applyStimulus(input bit doRead, input bit doWrite);
        bit accept;
        bit uf;
        int lvl;
        expT e;
        @(negedge clock);
        #1;
        if (doWrite && (wrCount - rdCount) < DEPTH) wrCount++;
        wGray = (SL+1)'(grayOf(wrCount % MODV));
        rdEn  = doRead;
        accept  = doRead && !mEmpty;
        uf      = doRead && mEmpty;
        rdCount = rdCount + (accept ? 1 : 0);
        lvl     = syncPipe[SS-1] - rdCount;
        e.bin   = rdCount % MODV;
        e.lvl   = lvl;
        e.emp   = (lvl == 0);
        e.ae    = (lvl <= AET);
        e.uf    = uf;
        mEmpty  = e.emp;
        for (int i = SS - 1; i > 0; i--) syncPipe[i] = syncPipe[i-1];
        syncPipe[0] = wrCount;
        expQ.push_back(e);
    endtask

    // Asserts reset away from the clock edge and checks that the outputs
    // clear without waiting for an edge. It then holds reset across two
    // edges and releases it with the model and write pointer cleared.
    task automatic applyReset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        rdEn  = 1'b0;
        #1;
        compare("rst_ptr_bin",      32'(ptrBin),      0);
        compare("rst_ptr_gray",     32'(ptrGray),     0);
        compare("rst_addr",         32'(addr),        0);
        compare("rst_level",        32'(level),       0);
        compare("rst_empty",        32'(empty),       1);
        compare("rst_almost_empty", 32'(almostEmpty), 1);
        compare("rst_underflow",    32'(underflow),   0);
        repeat (2) @(negedge clock);
        #1;
        wrCount = 0;
        rdCount = 0;
        for (int i = 0; i < SS; i++) syncPipe[i] = 0;
        mEmpty = 1'b1;
        wGray  = '0;
        reset  = 1'b0;
    endtask

    // Monitor: after every edge, check the oldest outstanding expectation.
    initial begin
        expT e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        for (int i = 0; i < SS; i++) syncPipe[i] = 0;
        applyReset();

        // A single write step; empty must fall exactly SYNC_STAGES+1 edges later.
        repeat (2) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0);

        // Fill to four words, then drain with a continuous read request
        // that runs past empty into underflow.
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0);
        repeat (7) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Full view: 32 outstanding words, then a single read.
        applyReset();
        repeat (DEPTH) applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Interleaved traffic: writer-heavy, reader-heavy, then balanced.
        // This carries the pointers through several wraps.
        repeat (200) applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        applyReset();
        repeat (200) applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        repeat (250) applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

        // Reset in the middle of a burst, followed by more traffic.
        repeat (20) applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b1);
        applyReset();
        repeat (100) applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);

        repeat (3) @(negedge clock);
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
